// File: rtl/gpu_pkg.sv
// Shared types and constants for the text-mode GPU command path.
package gpu_pkg;

  localparam int TEXT_W_DEF = 80;
  localparam int TEXT_H_DEF = 60;

  typedef enum logic [1:0] {
    OP_STORE   = 2'b00,
    OP_MOVE    = 2'b01,
    OP_DISPLAY = 2'b10,
    OP_CLEAR   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } state_e;

  function automatic int cell_count(input int w, input int h);
    return w * h;
  endfunction

  localparam int CELLS_DEF = cell_count(TEXT_W_DEF, TEXT_H_DEF);

endpackage

// File: rtl/gpu_text_cursor.sv
// Text cursor: column/row registers with advance, relative move (mod size) and home.
module gpu_text_cursor
  import gpu_pkg::*;
#(
  parameter int TEXT_W = TEXT_W_DEF,
  parameter int TEXT_H = TEXT_H_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic       move,
  input  logic       home,
  input  logic [7:0] move_data,
  output logic [6:0] cur_x,
  output logic [5:0] cur_y
);

  localparam logic [7:0] XW     = 8'(TEXT_W);
  localparam logic [7:0] XW2    = 8'(2 * TEXT_W);
  localparam logic [6:0] YH     = 7'(TEXT_H);
  localparam logic [6:0] X_LAST = 7'(TEXT_W - 1);
  localparam logic [5:0] Y_LAST = 6'(TEXT_H - 1);

  // Sum of a column and a 7-bit offset never reaches 3*TEXT_W, so two compares suffice.
  function automatic logic [6:0] wrap_x(input logic [7:0] s);
    if (s >= XW2)     return 7'(s - XW2);
    else if (s >= XW) return 7'(s - XW);
    else              return s[6:0];
  endfunction

  function automatic logic [5:0] wrap_y(input logic [6:0] s);
    if (s >= YH) return 6'(s - YH);
    else         return s[5:0];
  endfunction

  logic [7:0] x_sum;
  logic [6:0] y_sum;

  assign x_sum = {1'b0, cur_x} + {1'b0, move_data[6:0]};
  assign y_sum = {1'b0, cur_y} + {1'b0, move_data[5:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_x <= '0;
      cur_y <= '0;
    end else if (home) begin
      cur_x <= '0;
      cur_y <= '0;
    end else if (advance) begin
      if (cur_x == X_LAST) begin
        cur_x <= '0;
        cur_y <= (cur_y == Y_LAST) ? '0 : cur_y + 6'd1;
      end else begin
        cur_x <= cur_x + 7'd1;
      end
    end else if (move) begin
      if (move_data[7]) cur_x <= wrap_x(x_sum);
      else              cur_y <= wrap_y(y_sum);
    end
  end

endmodule

// File: rtl/gpu_cmd_ctrl.sv
// Host command sequencer: drives the glyph RAM write port and defers buffer swaps to vblank.
module gpu_cmd_ctrl
  import gpu_pkg::*;
#(
  parameter int TEXT_W = TEXT_W_DEF,
  parameter int TEXT_H = TEXT_H_DEF,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        cmd_data,
  input  logic              vblank_start,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              active_buf,
  output logic [6:0]        cursor_x,
  output logic [5:0]        cursor_y,
  output logic              busy
);

  localparam int                CELLS     = cell_count(TEXT_W, TEXT_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  state_e            state, state_d;
  logic              wr_en_d, active_d;
  logic [ADDR_W-1:0] wr_addr_d, clr_cnt, clr_cnt_d, store_addr;
  logic [7:0]        wr_data_d, fill, fill_d;
  logic              clr_done, clr_done_d;
  logic              cur_adv, cur_move, cur_home;

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign wr_bank    = ~active_buf;
  assign store_addr = ADDR_W'(cursor_y) * ADDR_W'(TEXT_W) + ADDR_W'(cursor_x);

  gpu_text_cursor #(
    .TEXT_W(TEXT_W),
    .TEXT_H(TEXT_H)
  ) u_cursor (
    .clk      (clk),
    .reset    (reset),
    .advance  (cur_adv),
    .move     (cur_move),
    .home     (cur_home),
    .move_data(cmd_data),
    .cur_x    (cursor_x),
    .cur_y    (cursor_y)
  );

  always_comb begin
    state_d    = state;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    active_d   = active_buf;
    fill_d     = fill;
    clr_cnt_d  = clr_cnt;
    clr_done_d = clr_done;
    cur_adv    = 1'b0;
    cur_move   = 1'b0;
    cur_home   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_STORE: begin
              wr_en_d   = 1'b1;
              wr_addr_d = store_addr;
              wr_data_d = cmd_data;
              cur_adv   = 1'b1;
            end
            OP_MOVE:    cur_move = 1'b1;
            OP_DISPLAY: state_d  = ST_SWAP_WAIT;
            OP_CLEAR: begin
              state_d    = ST_CLEAR;
              fill_d     = cmd_data;
              clr_cnt_d  = '0;
              clr_done_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      // clr_done marks that the last cell write is on the port; leave the cycle after it.
      ST_CLEAR: begin
        if (clr_done) begin
          state_d  = ST_IDLE;
          cur_home = 1'b1;
        end else begin
          wr_en_d    = 1'b1;
          wr_addr_d  = clr_cnt;
          wr_data_d  = fill;
          clr_cnt_d  = clr_cnt + 1'b1;
          clr_done_d = (clr_cnt == LAST_ADDR);
        end
      end
      ST_SWAP_WAIT: begin
        if (vblank_start) begin
          active_d = ~active_buf;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      active_buf <= 1'b0;
      clr_cnt    <= '0;
      clr_done   <= 1'b0;
    end else begin
      state      <= state_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      active_buf <= active_d;
      clr_cnt    <= clr_cnt_d;
      clr_done   <= clr_done_d;
    end
  end

  always_ff @(posedge clk) begin
    fill <= fill_d;
  end

endmodule

// File: tb/tb_gpu_cmd_ctrl.sv
// Scoreboard bench for gpu_cmd_ctrl: expected writes queued on issue, checked on wr_en.
module tb_gpu_cmd_ctrl;

  localparam int TW    = 80;
  localparam int TH    = 60;
  localparam int AW    = 13;
  localparam int NCELL = TW * TH;

  localparam logic [1:0] C_STORE   = 2'b00;
  localparam logic [1:0] C_MOVE    = 2'b01;
  localparam logic [1:0] C_DISPLAY = 2'b10;
  localparam logic [1:0] C_CLEAR   = 2'b11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [7:0]    cmd_data = 8'h00;
  logic          vblank_start = 1'b0;
  logic          wr_en, wr_bank, active_buf, busy;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [6:0]    cursor_x;
  logic [5:0]    cursor_y;

  gpu_cmd_ctrl #(.TEXT_W(TW), .TEXT_H(TH), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .vblank_start(vblank_start),
    .wr_en       (wr_en),
    .wr_bank     (wr_bank),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .active_buf  (active_buf),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          bank;
  } wr_t;

  wr_t  sbq[$];
  wr_t  exp_w;
  int   n_vec = 0;
  int   n_err = 0;
  int   mx = 0;
  int   my = 0;
  logic ma = 1'b0;

  // Write-port monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write addr=%0d data=%02h bank=%0d, none queued", wr_addr, wr_data, wr_bank);
      end else begin
        exp_w = sbq.pop_front();
        if ({wr_addr, wr_data, wr_bank} !== exp_w) begin
          n_err++;
          $display("FAIL write got addr=%0d data=%02h bank=%0d, want addr=%0d data=%02h bank=%0d",
                   wr_addr, wr_data, wr_bank, exp_w.addr, exp_w.data, exp_w.bank);
        end
      end
    end
  end

  task automatic push_store(input logic [7:0] d);
    wr_t w;
    w.addr = AW'(my * TW + mx);
    w.data = d;
    w.bank = ~ma;
    sbq.push_back(w);
    mx++;
    if (mx == TW) begin
      mx = 0;
      my++;
      if (my == TH) my = 0;
    end
  endtask

  task automatic push_fill(input logic [7:0] d, input int n);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      w.addr = AW'(i);
      w.data = d;
      w.bank = ~ma;
      sbq.push_back(w);
    end
  endtask

  // Entered and left at a negedge; holds the command for exactly one accepting edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic vb);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_ready cmd_ready=%b after %0d cycles, want 1", cmd_ready, w);
    end
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_data     = d;
    vblank_start = vb;
    if (op == C_STORE) push_store(d);
    if (op == C_MOVE) begin
      if (d[7]) mx = (mx + int'(d[6:0])) % TW;
      else      my = (my + int'(d[5:0])) % TH;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid    = 1'b0;
    vblank_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({cmd_ready, busy, wr_en, wr_bank, active_buf} !== 5'b10010) begin
      n_err++;
      $display("FAIL reset_ctrl ready/busy/wr_en/bank/active=%b, want 10010",
               {cmd_ready, busy, wr_en, wr_bank, active_buf});
    end
    n_vec++;
    if (wr_addr !== '0 || wr_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_port addr=%0d data=%02h, want 0 00", wr_addr, wr_data);
    end
    n_vec++;
    if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
      n_err++;
      $display("FAIL reset_cursor got %0d,%0d want 0,0", cursor_x, cursor_y);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_pair();
    issue(C_STORE, 8'h41, 1'b0);
    n_vec++;
    if (wr_en !== 1'b1 || wr_addr !== 13'd0) begin
      n_err++;
      $display("FAIL store1_timing wr_en=%b addr=%0d, want 1 0", wr_en, wr_addr);
    end
    issue(C_STORE, 8'h42, 1'b0);
    n_vec++;
    if (wr_en !== 1'b1 || wr_addr !== 13'd1) begin
      n_err++;
      $display("FAIL store2_timing wr_en=%b addr=%0d, want 1 1", wr_en, wr_addr);
    end
    n_vec++;
    if (cursor_x !== 7'd2 || cursor_y !== 6'd0) begin
      n_err++;
      $display("FAIL store_cursor got %0d,%0d want 2,0", cursor_x, cursor_y);
    end
    @(negedge clk);
    n_vec++;
    if (wr_en !== 1'b0 || wr_data !== 8'h42) begin
      n_err++;
      $display("FAIL store_idle wr_en=%b data=%02h, want 0 42", wr_en, wr_data);
    end
  endtask

  task automatic test_wrap_edges();
    issue(C_MOVE, 8'h80 | 8'd77, 1'b0);
    n_vec++;
    if (cursor_x !== 7'd79 || cursor_y !== 6'd0) begin
      n_err++;
      $display("FAIL move_to_79 got %0d,%0d want 79,0", cursor_x, cursor_y);
    end
    issue(C_STORE, 8'h20, 1'b0);
    n_vec++;
    if (cursor_x !== 7'd0 || cursor_y !== 6'd1) begin
      n_err++;
      $display("FAIL row_wrap got %0d,%0d want 0,1", cursor_x, cursor_y);
    end
    issue(C_MOVE, 8'd58, 1'b0);
    issue(C_MOVE, 8'h80 | 8'd79, 1'b0);
    n_vec++;
    if (cursor_x !== 7'd79 || cursor_y !== 6'd59) begin
      n_err++;
      $display("FAIL move_to_last got %0d,%0d want 79,59", cursor_x, cursor_y);
    end
    issue(C_STORE, 8'h5A, 1'b0);
    n_vec++;
    if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
      n_err++;
      $display("FAIL screen_wrap got %0d,%0d want 0,0", cursor_x, cursor_y);
    end
  endtask

  task automatic test_move_mod();
    issue(C_MOVE, 8'h80 | 8'd70, 1'b0);
    issue(C_MOVE, 8'hFF, 1'b0);
    n_vec++;
    if (cursor_x !== 7'd37) begin
      n_err++;
      $display("FAIL move_x_sub160 got %0d want 37", cursor_x);
    end
    issue(C_MOVE, 8'h80 | 8'd50, 1'b0);
    n_vec++;
    if (cursor_x !== 7'd7) begin
      n_err++;
      $display("FAIL move_x_sub80 got %0d want 7", cursor_x);
    end
    issue(C_MOVE, 8'd50, 1'b0);
    issue(C_MOVE, 8'h3F, 1'b0);
    n_vec++;
    if (cursor_y !== 6'd53 || cursor_x !== 7'd7) begin
      n_err++;
      $display("FAIL move_y_wrap got %0d,%0d want 7,53", cursor_x, cursor_y);
    end
  endtask

  task automatic test_display();
    issue(C_DISPLAY, 8'h00, 1'b1);
    n_vec++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1 || active_buf !== 1'b0) begin
      n_err++;
      $display("FAIL swap_wait_entry ready=%b busy=%b active=%b, want 0 1 0", cmd_ready, busy, active_buf);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_vec++;
      if (cmd_ready !== 1'b0 || active_buf !== 1'b0) begin
        n_err++;
        $display("FAIL swap_hold cyc=%0d ready=%b active=%b, want 0 0", i, cmd_ready, active_buf);
      end
    end
    vblank_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vblank_start = 1'b0;
    ma = ~ma;
    n_vec++;
    if (active_buf !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || wr_bank !== 1'b0) begin
      n_err++;
      $display("FAIL swap_done active=%b ready=%b busy=%b bank=%b, want 1 1 0 0",
               active_buf, cmd_ready, busy, wr_bank);
    end
    n_vec++;
    if (cursor_x !== 7'(mx) || cursor_y !== 6'(my)) begin
      n_err++;
      $display("FAIL swap_cursor got %0d,%0d want %0d,%0d", cursor_x, cursor_y, mx, my);
    end
    issue(C_STORE, 8'h33, 1'b0);
  endtask

  task automatic test_clear();
    issue(C_MOVE, 8'h80 | 8'((5 - mx + TW) % TW), 1'b0);
    issue(C_MOVE, 8'((5 - my + TH) % TH), 1'b0);
    n_vec++;
    if (cursor_x !== 7'd5 || cursor_y !== 6'd5) begin
      n_err++;
      $display("FAIL clear_setup got %0d,%0d want 5,5", cursor_x, cursor_y);
    end
    push_fill(8'h00, NCELL);
    issue(C_CLEAR, 8'h00, 1'b0);
    n_vec++;
    if (cmd_ready !== 1'b0 || wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL clear_accept ready=%b wr_en=%b, want 0 0", cmd_ready, wr_en);
    end
    for (int k = 0; k < NCELL; k++) begin
      @(negedge clk);
      vblank_start = (k == 100);
      n_vec++;
      if (wr_en !== 1'b1 || wr_addr !== AW'(k) || cmd_ready !== 1'b0) begin
        n_err++;
        $display("FAIL clear_seq k=%0d wr_en=%b addr=%0d ready=%b, want 1 %0d 0", k, wr_en, wr_addr, cmd_ready, k);
      end
    end
    vblank_start = 1'b0;
    @(negedge clk);
    mx = 0;
    my = 0;
    n_vec++;
    if (cmd_ready !== 1'b1 || wr_en !== 1'b0 || cursor_x !== 7'd0 || cursor_y !== 6'd0 || active_buf !== ma) begin
      n_err++;
      $display("FAIL clear_end ready=%b wr_en=%b cursor=%0d,%0d active=%b, want 1 0 0,0 %b",
               cmd_ready, wr_en, cursor_x, cursor_y, active_buf, ma);
    end
  endtask

  task automatic test_reset_mid_clear();
    int w;
    push_fill(8'hAA, 1001);
    issue(C_CLEAR, 8'hAA, 1'b0);
    w = 0;
    while (!(wr_en === 1'b1 && wr_addr === 13'd1000) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (w >= 3000) begin
      n_err++;
      $display("FAIL abort_reach addr=%0d after %0d cycles, want write at 1000", wr_addr, w);
    end
    reset = 1'b1;
    #1;
    ma = 1'b0;
    mx = 0;
    my = 0;
    n_vec++;
    if (wr_en !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || active_buf !== 1'b0 ||
        cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
      n_err++;
      $display("FAIL abort_state wr_en=%b ready=%b busy=%b active=%b cursor=%0d,%0d, want 0 1 0 0 0,0",
               wr_en, cmd_ready, busy, active_buf, cursor_x, cursor_y);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL abort_queue %0d writes outstanding, want 0", sbq.size());
    end
    issue(C_STORE, 8'h7E, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_store_pair();
    test_wrap_edges();
    test_move_mod();
    test_display();
    test_clear();
    test_reset_mid_clear();
    repeat (3) @(negedge clk);
    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL final_queue %0d writes never seen, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpu_cmd_ctrl.md
Name: gpu_cmd_ctrl

Overview:
Command sequencer for the text-mode GPU. It accepts host commands (store byte, move cursor, display/swap, clear) over a valid/ready handshake. It maintains the text cursor and the active/back buffer select, and drives the single write port of the double-buffered glyph RAM. Buffer swaps are deferred to the vblank start pulse from the scanout timing, so the front buffer never tears.

Parameters:
TEXT_W, 80, text columns.
TEXT_H, 60, text rows.
ADDR_W, 13, glyph RAM cell address width; must satisfy 2**ADDR_W >= TEXT_W*TEXT_H.

Ports:
clk  in  1  system/pixel clock; all logic on posedge.
reset  in  1  asynchronous, active-high reset.
cmd_valid  in  1  host command present.
cmd_ready  out  1  controller can accept; high only in IDLE.
cmd_op  in  2  00 STORE_BYTE, 01 MOVE_CURSOR, 10 DISPLAY, 11 CLEAR.
cmd_data  in  8  command operand.
vblank_start  in  1  one-cycle pulse at start of vertical blanking.
wr_en  out  1  glyph RAM write strobe.
wr_bank  out  1  bank written; always the back buffer (~active_buf).
wr_addr  out  ADDR_W  cell index y*TEXT_W + x.
wr_data  out  8  glyph code.
active_buf  out  1  front buffer read by scanout.
cursor_x  out  7  current column, 0..TEXT_W-1.
cursor_y  out  6  current row, 0..TEXT_H-1.
busy  out  1  high in CLEAR or SWAP_WAIT.

Behaviour:
- Reset (async) sets: state IDLE, cmd_ready=1, busy=0, wr_en=0, wr_addr=0, wr_data=0, wr_bank=1, active_buf=0, cursor 0,0. All outputs are registered except cmd_ready, busy and wr_bank, which decode from state/active_buf.
- A command is accepted on a posedge with cmd_valid && cmd_ready. Ops are decoded only on accept.
- States: IDLE, CLEAR, SWAP_WAIT.
- STORE_BYTE (IDLE->IDLE):
  - Next cycle: wr_en=1, wr_addr=cursor_y*TEXT_W+cursor_x, wr_data=cmd_data.
  - Cursor advances by one column. At x==TEXT_W-1, x wraps to 0 and y increments. At y==TEXT_H-1 with that x wrap, y wraps to 0.
  - Back-to-back STOREs are accepted every cycle, giving one write per cycle.
- MOVE_CURSOR (IDLE->IDLE), no write:
  - cmd_data[7]=1: x = (x + cmd_data[6:0]) mod TEXT_W. The 8-bit sum is at most 206; subtract 160 if >=160, else subtract 80 if >=80.
  - cmd_data[7]=0: y = (y + cmd_data[5:0]) mod TEXT_H. The sum is at most 122; subtract 60 if >=60.
  - The update is visible on the cursor outputs next cycle.
- DISPLAY (IDLE->SWAP_WAIT):
  - A vblank_start in the accept cycle is ignored.
  - In SWAP_WAIT, the first vblank_start toggles active_buf (registered) and returns to IDLE.
  - Cursor is unchanged.
- CLEAR (IDLE->CLEAR):
  - Fill byte = cmd_data, latched on accept.
  - Issues TEXT_W*TEXT_H consecutive writes to the back bank: addresses 0..4799, one per cycle, first write the cycle after accept.
  - After the write to address 4799: state returns to IDLE, cursor is set to 0,0, and cmd_ready is 1 the following cycle.
  - vblank_start is ignored during CLEAR.
- wr_en is low in every cycle without a write. wr_addr and wr_data hold their last values when idle.
- The swap takes effect on active_buf only; writes issued before the swap edge target the old back bank.
- Reset mid-CLEAR or mid-SWAP_WAIT aborts immediately. The partial fill is left in RAM; no swap occurs.
- Undefined op values do not exist (2-bit, all decoded).

Decomposition:
- gpu_pkg: TEXT_W/TEXT_H defaults, op-code localparams/enum (OP_STORE, OP_MOVE, OP_DISPLAY, OP_CLEAR), state enum (ST_IDLE, ST_CLEAR, ST_SWAP_WAIT), cell-count constant.
- One sub-module, gpu_text_cursor: holds x/y and applies advance/move/home with the mod arithmetic above. The controller FSM and write-port registers stay in gpu_cmd_ctrl.

Test Plan:
- Reset, STORE 0x41 then 0x42 -> writes (addr 0, 0x41, bank 1) and (addr 1, 0x42, bank 1) on consecutive cycles; cursor ends at 2,0.
- MOVE 0x80|79 to reach x=79, y=0; STORE 0x20 -> write at addr 79; cursor 0,1. Then MOVE y by 58 (to y=59), MOVE 0x80|79, STORE -> write at addr 4799; cursor wraps to 0,0.
- At x=70, MOVE 0xFF (+127) -> x=37. At y=50, MOVE 0x3F (+63) -> y=53.
- DISPLAY with vblank_start pulsed in the accept cycle and again 10 cycles later -> active_buf toggles only after the second pulse. cmd_ready is low in between, and the next STORE writes bank 0.
- CLEAR 0x00 at cursor 5,5 -> exactly 4800 writes at addr 0..4799 in consecutive cycles. cmd_ready is low throughout and high one cycle after the last write; cursor 0,0.
- Assert reset at clear address 1000 -> wr_en=0, state IDLE, cmd_ready=1, cursor 0,0, active_buf=0 immediately; no further writes.
